// File: rtl/serializer_lanes_if.sv
// Handshake bundle for serializer_lanes: a parallel word input stream and a LANES-wide beat output stream.
// master = the surrounding upstream/downstream logic, slave = the serializer itself.
interface serializer_lanes_if #(
  parameter int WORD_W = 24,
  parameter int LANES  = 1
);
  logic [WORD_W-1:0] iv_din;
  logic              i_din_valid;
  logic              o_din_ready;
  logic [LANES-1:0]  ov_dout;
  logic              o_dout_valid;
  logic              o_dout_last;
  logic              i_dout_ready;

  modport master (
    output iv_din, i_din_valid, i_dout_ready,
    input  o_din_ready, ov_dout, o_dout_valid, o_dout_last
  );

  modport slave (
    input  iv_din, i_din_valid, i_dout_ready,
    output o_din_ready, ov_dout, o_dout_valid, o_dout_last
  );
endinterface

// File: rtl/serializer_lanes.sv
// Parallel-to-serial converter: splits WORD_W-bit words into WORD_W/LANES beats, LSB- or MSB-first,
// with a one-word holding register so back-to-back words stream without bubbles.
module serializer_lanes #(
  parameter int WORD_W    = 24,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  serializer_lanes_if.slave bus
);
  localparam int BEATS = WORD_W / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (WORD_W % LANES != 0) begin : g_bad_lanes
    $error("serializer_lanes: WORD_W must be a multiple of LANES");
  end

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;

  logic              active;
  logic              din_ready;
  logic              dout_valid;
  logic              last_beat;
  logic              in_xfer;
  logic              out_xfer;
  logic [WORD_W-1:0] shifted;
  logic [LANES-1:0]  beat;

  // Readiness depends only on registered state plus enable/reset, never on i_din_valid.
  assign active     = i_en & ~i_rst;
  assign din_ready  = active & ~hold_valid_q;
  assign dout_valid = active & (state_q == SHIFT);
  assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));
  assign in_xfer    = bus.i_din_valid & din_ready;
  assign out_xfer   = dout_valid & bus.i_dout_ready;
  assign shifted    = MSB_FIRST ? (shift_q << LANES) : (shift_q >> LANES);
  assign beat       = MSB_FIRST ? shift_q[WORD_W-1 -: LANES] : shift_q[LANES-1:0];

  assign bus.o_din_ready  = din_ready;
  assign bus.o_dout_valid = dout_valid;
  assign bus.o_dout_last  = dout_valid & last_beat;
  assign bus.ov_dout      = (~i_rst && state_q == SHIFT) ? beat : '0;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          shift_d = bus.iv_din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_xfer && last_beat) begin
          // Word boundary: refill from hold first, else take the incoming word directly.
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            cnt_d        = '0;
          end else if (in_xfer) begin
            shift_d = bus.iv_din;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (out_xfer) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
          if (in_xfer) begin
            hold_d       = bus.iv_din;
            hold_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (i_en) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
endmodule

// File: tb/tb_serializer_lanes.sv
// Directed bench for serializer_lanes: three instances (1-lane LSB-first, 4-lane MSB-first, 24-lane)
// driven with hand-computed vectors.
module tb_serializer_lanes;
  logic clk = 1'b0;
  logic rst;
  logic en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serializer_lanes_if #(.WORD_W(24), .LANES(1))  b0 ();
  serializer_lanes_if #(.WORD_W(24), .LANES(4))  b1 ();
  serializer_lanes_if #(.WORD_W(24), .LANES(24)) b2 ();

  serializer_lanes #(.WORD_W(24), .LANES(1), .MSB_FIRST(1'b0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .bus(b0)
  );
  serializer_lanes #(.WORD_W(24), .LANES(4), .MSB_FIRST(1'b1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .bus(b1)
  );
  serializer_lanes #(.WORD_W(24), .LANES(24), .MSB_FIRST(1'b0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .bus(b2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle point: 1 time unit after the falling edge; inputs are driven here, outputs checked 1 unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Streams beats from..to of word w out of the 1-lane instance with ready held high.
  task automatic u0_beats(input string tag, input logic [23:0] w, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      tick();
      en             = 1'b1;
      b0.i_din_valid = 1'b0;
      b0.i_dout_ready = 1'b1;
      #1;
      check({tag, "_valid"}, b0.o_dout_valid, 1);
      check({tag, "_bit"},   b0.ov_dout,      w[k]);
      check({tag, "_last"},  b0.o_dout_last,  (k == 23));
    end
  endtask

  logic [3:0]  nib_exp [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
  logic [23:0] w1, w2, w_bad;
  int          idx;
  int          cycles;
  logic        rdy;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    b0.iv_din = '0; b0.i_din_valid = 1'b0; b0.i_dout_ready = 1'b1;
    b1.iv_din = '0; b1.i_din_valid = 1'b0; b1.i_dout_ready = 1'b1;
    b2.iv_din = '0; b2.i_din_valid = 1'b0; b2.i_dout_ready = 1'b1;

    // Reset: everything quiet while i_rst is high.
    tick(); tick();
    b0.i_din_valid = 1'b1;
    #1;
    check("rst_din_ready", b0.o_din_ready,  0);
    check("rst_valid",     b0.o_dout_valid, 0);
    check("rst_last",      b0.o_dout_last,  0);
    check("rst_dout",      b0.ov_dout,      0);
    check("rst_u2_ready",  b2.o_din_ready,  0);
    tick();
    rst = 1'b0;
    b0.i_din_valid = 1'b0;
    #1;
    check("idle_din_ready", b0.o_din_ready,  1);
    check("idle_valid",     b0.o_dout_valid, 0);

    // Test 1: single word, 1 lane, LSB-first.
    b0.iv_din = 24'hA5F00F; b0.i_din_valid = 1'b1;
    #1;
    check("t1_accept_valid", b0.o_dout_valid, 0);
    u0_beats("t1", 24'hA5F00F, 0, 23);
    tick();
    check("t1_idle_valid", b0.o_dout_valid, 0);
    check("t1_idle_dout",  b0.ov_dout,      0);

    // Test 2: back-to-back words, 48 contiguous beats.
    w1 = 24'h123456; w2 = 24'hABCDEF;
    b0.iv_din = w1; b0.i_din_valid = 1'b1;
    #1;
    check("t2_ready0", b0.o_din_ready, 1);
    for (int k = 0; k < 48; k++) begin
      tick();
      if (k == 0) begin
        b0.iv_din = w2; b0.i_din_valid = 1'b1;
      end else begin
        b0.i_din_valid = 1'b0;
      end
      #1;
      check("t2_valid",     b0.o_dout_valid, 1);
      check("t2_bit",       b0.ov_dout,      (k < 24) ? w1[k] : w2[k-24]);
      check("t2_last",      b0.o_dout_last,  (k == 23 || k == 47));
      check("t2_din_ready", b0.o_din_ready,  (k == 0 || k >= 24));
    end
    tick();
    check("t2_idle_valid", b0.o_dout_valid, 0);

    // Test 3: 4 lanes MSB-first with ready toggling 1,0,1,0.
    b1.iv_din = 24'h123456; b1.i_din_valid = 1'b1; b1.i_dout_ready = 1'b1;
    tick();
    b1.i_din_valid = 1'b0;
    idx = 0; rdy = 1'b1; cycles = 0;
    while (idx < 6 && cycles < 20) begin
      b1.i_dout_ready = rdy;
      #1;
      check("t3_valid", b1.o_dout_valid, 1);
      check("t3_nib",   b1.ov_dout,      nib_exp[idx]);
      check("t3_last",  b1.o_dout_last,  (idx == 5));
      if (rdy) idx++;
      rdy = ~rdy;
      cycles++;
      tick();
    end
    b1.i_dout_ready = 1'b1;
    #1;
    check("t3_done",       idx,             6);
    check("t3_idle_valid", b1.o_dout_valid, 0);

    // Test 4: clock enable low for 5 cycles while beat index 7 is presented.
    w1 = 24'h5A3C96;
    b0.iv_din = w1; b0.i_din_valid = 1'b1;
    #1;
    u0_beats("t4a", w1, 0, 6);
    for (int c = 0; c < 5; c++) begin
      tick();
      en = 1'b0;
      b0.iv_din = 24'hFFFFFF; b0.i_din_valid = 1'b1;
      #1;
      check("t4_off_valid", b0.o_dout_valid, 0);
      check("t4_off_ready", b0.o_din_ready,  0);
      check("t4_off_last",  b0.o_dout_last,  0);
      check("t4_off_dout",  b0.ov_dout,      w1[7]);
    end
    u0_beats("t4b", w1, 7, 23);
    tick();
    check("t4_idle_valid", b0.o_dout_valid, 0);

    // Test 5: reset at beat index 10 with a word waiting in hold.
    w1 = 24'h0F0F0F; w_bad = 24'hFFFFFF;
    b0.iv_din = w1; b0.i_din_valid = 1'b1;
    tick();
    b0.iv_din = w_bad; b0.i_din_valid = 1'b1;
    #1;
    check("t5_ready_b0", b0.o_din_ready, 1);
    u0_beats("t5a", w1, 1, 9);
    check("t5_hold_full", b0.o_din_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    check("t5_rst_valid", b0.o_dout_valid, 0);
    check("t5_rst_ready", b0.o_din_ready,  0);
    check("t5_rst_last",  b0.o_dout_last,  0);
    check("t5_rst_dout",  b0.ov_dout,      0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_post_valid", b0.o_dout_valid, 0);
    check("t5_post_ready", b0.o_din_ready,  1);
    b0.iv_din = 24'h000001; b0.i_din_valid = 1'b1;
    u0_beats("t5b", 24'h000001, 0, 23);
    tick();
    check("t5_idle_valid", b0.o_dout_valid, 0);

    // Test 6: 24 lanes, one word per cycle through the bypass path.
    b2.iv_din = 24'h000100; b2.i_din_valid = 1'b1; b2.i_dout_ready = 1'b1;
    #1;
    check("t6_ready0", b2.o_din_ready, 1);
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n < 8) b2.iv_din = 24'h000100 + 24'(n);
      else       b2.i_din_valid = 1'b0;
      #1;
      check("t6_valid", b2.o_dout_valid, 1);
      check("t6_dout",  b2.ov_dout,      24'h000100 + 24'(n - 1));
      check("t6_last",  b2.o_dout_last,  1);
      check("t6_ready", b2.o_din_ready,  1);
    end
    tick();
    check("t6_idle_valid", b2.o_dout_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
